alu_issue_queue: RTL and testbench

// Buffered command-issue front end for the pipelined 16-bit ALU. Accepts {opcode,A,B,tag} over valid/ready,

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_sync_fifo.sv | 48 ++++
 rtl/alu_issue_queue.sv | 157 +++++++++++++++
 tb/tb_alu_issue_queue.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the 16-bit pipelined ALU and its command-issue front end.
package alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_NOT    = 4'd5;
  localparam logic [3:0] OP_LSHIFT = 4'd6;
  localparam logic [3:0] OP_RSHIFT = 4'd7;
  localparam logic [3:0] OP_CMP    = 4'd8;
  localparam logic [3:0] OP_LAST   = OP_CMP;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op > OP_LAST;
  endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// Single-clock FIFO with registered storage; the head word is driven straight from storage.
module alu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/alu_issue_queue.sv
// Buffered issue front end for the fixed-latency 16-bit ALU: command queue, credit-gated issue,
// latency tracking pipe and a result buffer that lets the consumer stall without losing results.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int IN_DEPTH    = 4,
  parameter int OUT_DEPTH   = 4,
  parameter int ALU_LATENCY = 2,
  parameter int TAG_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_flags,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_illegal
);

  localparam int IN_W  = 4 + 2*DATA_W + TAG_W;
  localparam int OUT_W = DATA_W + 4 + TAG_W + 1;
  localparam int CRD_W = $clog2(OUT_DEPTH + 1);

  function automatic logic [DATA_W-1:0] squash_data(input logic ill, input logic [DATA_W-1:0] d);
    return ill ? '0 : d;
  endfunction

  function automatic logic [3:0] squash_flags(input logic ill, input logic [3:0] f);
    return ill ? 4'h0 : f;
  endfunction

  logic [IN_W-1:0]            in_rd_data;
  logic                       in_full;
  logic                       in_empty;
  logic [$clog2(IN_DEPTH):0]  in_count;
  logic [3:0]                 hd_op;
  logic [DATA_W-1:0]          hd_a;
  logic [DATA_W-1:0]          hd_b;
  logic [TAG_W-1:0]           hd_tag;
  logic                       hd_ill;
  logic                       issue;

  logic [ALU_LATENCY-1:0]     vld_p;
  logic [ALU_LATENCY-1:0]     ill_p;
  logic [TAG_W-1:0]           tag_p [ALU_LATENCY];

  logic [CRD_W-1:0]           credit;
  logic [OUT_W-1:0]           out_wr_data;
  logic [OUT_W-1:0]           out_rd_data;
  logic                       out_full;
  logic                       out_empty;
  logic [$clog2(OUT_DEPTH):0] out_count;
  logic                       out_pop;
  logic                       unused_fifo_status;

  assign in_ready = rst_n & ~in_full;

  alu_sync_fifo #(.WIDTH(IN_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid & in_ready),
    .wr_data ({in_opcode, in_a, in_b, in_tag}),
    .rd_en   (issue),
    .rd_data (in_rd_data),
    .full    (in_full),
    .empty   (in_empty),
    .count   (in_count)
  );

  assign {hd_op, hd_a, hd_b, hd_tag} = in_rd_data;
  assign hd_ill  = op_is_illegal(hd_op);
  assign issue   = ~in_empty & (credit != '0);
  assign out_pop = out_valid & out_ready;

  // Issue stage: bubbles and illegal ops both present ADD 0,0 to the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= OP_ADD;
      alu_a      <= '0;
      alu_b      <= '0;
    end else if (issue && !hd_ill) begin
      alu_opcode <= hd_op;
      alu_a      <= hd_a;
      alu_b      <= hd_b;
    end else begin
      alu_opcode <= OP_ADD;
      alu_a      <= '0;
      alu_b      <= '0;
    end
  end

  // Tracking pipe: stage i holds the op issued i+1 edges ago, aligned with the ALU's own pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      for (int i = ALU_LATENCY-1; i > 0; i--) vld_p[i] <= vld_p[i-1];
      vld_p[0] <= issue;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = ALU_LATENCY-1; i > 0; i--) begin
      tag_p[i] <= tag_p[i-1];
      ill_p[i] <= ill_p[i-1];
    end
    tag_p[0] <= hd_tag;
    ill_p[0] <= hd_ill;
  end

  // Credit covers in-flight plus buffered ops, so the result buffer can never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= CRD_W'(OUT_DEPTH);
    end else if (issue && !out_pop) begin
      credit <= credit - CRD_W'(1);
    end else if (!issue && out_pop) begin
      credit <= credit + CRD_W'(1);
    end
  end

  // Capture stage: tail of the tracking pipe meets the ALU result.
  assign out_wr_data = {squash_data(ill_p[ALU_LATENCY-1], alu_result),
                        squash_flags(ill_p[ALU_LATENCY-1], alu_flags),
                        tag_p[ALU_LATENCY-1],
                        ill_p[ALU_LATENCY-1]};

  alu_sync_fifo #(.WIDTH(OUT_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (vld_p[ALU_LATENCY-1]),
    .wr_data (out_wr_data),
    .rd_en   (out_ready),
    .rd_data (out_rd_data),
    .full    (out_full),
    .empty   (out_empty),
    .count   (out_count)
  );

  assign out_valid = ~out_empty;
  assign {out_result, out_flags, out_tag, out_illegal} = out_rd_data;

  assign unused_fifo_status = ^{in_count, out_count, out_full};

endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized scoreboard bench for alu_issue_queue with a behavioural latency-2 ALU on the alu_* ports.
module tb_alu_issue_queue;

  localparam int IN_DEPTH  = 4;
  localparam int OUT_DEPTH = 4;
  localparam int ALU_LAT   = 2;
  localparam int TAG_W     = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_result;
  logic [3:0]  alu_flags;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic [3:0]  out_tag;
  logic        out_illegal;

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  logic [24:0] exp_q [$];

  always #5 clk = ~clk;

  alu_issue_queue #(
    .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .ALU_LATENCY(ALU_LAT), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_tag(out_tag), .out_illegal(out_illegal)
  );

  // ALU semantics: result plus {Z,C,V,N}; C is carry for ADD, borrow for SUB/CMP, shifted-out bit for shifts.
  function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r, f;
    logic c, v;
    w = {1'b0, a} + {1'b0, b};
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin r = w[15:0]; c = w[16]; v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd1, 4'd8: begin r = a - b; c = (a < b); v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = a << 1; c = a[15]; end
      4'd7: begin r = a >> 1; c = a[0]; end
      default: r = '0;
    endcase
    f = r;
    if (op == 4'd8) r = '0;
    return {r, (f == 16'h0), c, v, f[15]};
  endfunction

  function automatic logic [24:0] model(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [3:0] tag);
    if (op > 4'd8) return {16'h0, 4'h0, tag, 1'b1};
    return {alu_fn(op, a, b), tag, 1'b0};
  endfunction

  // Behavioural ALU: one register stage after the registered alu_* inputs gives latency 2.
  logic [3:0]  s1_op = '0;
  logic [15:0] s1_a = '0, s1_b = '0;
  always @(posedge clk) begin
    s1_op <= alu_opcode;
    s1_a  <= alu_a;
    s1_b  <= alu_b;
  end
  assign {alu_result, alu_flags} = alu_fn(s1_op, s1_a, s1_b);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: checks the buffer head every cycle it is valid, pops on handshake, records accepts.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", 64'(out_valid), 64'(0));
      end else begin
        chk("out_head", 64'({out_result, out_flags, out_tag, out_illegal}), 64'(exp_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
      end
    end
    if (rst_n && in_valid && in_ready) exp_q.push_back(model(in_opcode, in_a, in_b, in_tag));
    if (rst_n) chk("credit_bound", 64'(int'(dut.credit) <= OUT_DEPTH), 64'(1));
  end

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] tag, input int budget, output bit ok);
    bit acc;
    int w;
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_tag = tag;
    ok = 1'b0; w = 0;
    while (!ok && w < budget) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      ok = acc;
      w++;
    end
  endtask

  task automatic single(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tag, input logic [15:0] er, input logic [3:0] ef,
                        input logic ei);
    bit ok;
    int n;
    send(op, a, b, tag, 10, ok);
    in_valid = 1'b0;
    chk("single_accept", 64'(ok), 64'(1));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("no_bypass", 64'({alu_opcode, alu_a, alu_b}), 64'(0));
      if (n == 2) chk("alu_issue", 64'({alu_opcode, alu_a, alu_b}), ei ? 64'(0) : 64'({op, a, b}));
    end while (!out_valid && n < 12);
    chk("latency", 64'(n - 1), 64'(ALU_LAT + 1));
    chk("single_result", 64'({out_result, out_flags, out_tag, out_illegal}), 64'({er, ef, tag, ei}));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int streak, acc_n, pops0, w;
    rst_n = 1'b1; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_alu", 64'({alu_opcode, alu_a, alu_b}), 64'(0));
    chk("rst_out_data", 64'({out_result, out_flags, out_tag, out_illegal}), 64'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    single(4'd0, 16'd12, 16'd34, 4'd1, 16'd46, 4'h0, 1'b0);
    single(4'd1, 16'd100, 16'd40, 4'd2, 16'd60, 4'h0, 1'b0);
    single(4'd2, 16'hF0F0, 16'h0FF0, 4'd3, 16'h00F0, 4'h0, 1'b0);
    single(4'hC, 16'd5, 16'd7, 4'd5, 16'h0, 4'h0, 1'b1);

    // Back-to-back stream with a free consumer.
    streak = 0;
    fork
      begin
        bit okb;
        for (int i = 0; i < 8; i++) begin
          send(4'($urandom_range(0, 8)), 16'($urandom), 16'($urandom), 4'(i), 5, okb);
          chk("b2b_accept", 64'(okb), 64'(1));
        end
        in_valid = 1'b0;
      end
      begin
        int wv;
        wv = 0;
        while (!out_valid && wv < 20) begin @(negedge clk); wv++; end
        while (out_valid && streak < 8) begin streak++; @(negedge clk); end
      end
    join
    chk("b2b_streak", 64'(streak), 64'(8));
    repeat (3) @(posedge clk);
    #1;

    // Stalled consumer: credit then input FIFO fill up.
    out_ready = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      send(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 4'(i), 6, ok);
      if (ok) acc_n++;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 64'(acc_n), 64'(IN_DEPTH + OUT_DEPTH));
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_credit", 64'(dut.credit), 64'(0));
    pops0 = n_pop;
    out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 60) begin @(posedge clk); w++; end
    #1;
    chk("bp_drained", 64'(n_pop - pops0), 64'(IN_DEPTH + OUT_DEPTH));
    repeat (3) @(posedge clk);
    #1;

    // Reset while ops are queued, in flight and buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(4'd3, 16'hA5A5, 16'h0101, 4'(i), 6, ok);
    in_valid = 1'b0;
    chk("pre_rst_buffered", 64'(out_valid), 64'(1));
    chk("pre_rst_alu_a", 64'(alu_a), 64'(16'hA5A5));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_alu", 64'({alu_opcode, alu_a, alu_b}), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_idle", 64'(out_valid), 64'(0));

    // Random traffic against a randomly stalling consumer.
    fork
      begin
        bit okr;
        for (int i = 0; i < 60; i++) begin
          send(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 4'($urandom), 60, okr);
          chk("rnd_accept", 64'(okr), 64'(1));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 200; c++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin @(posedge clk); w++; end
    #1;
    chk("rnd_drain", 64'(exp_q.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;

    // Sustained issue with simultaneous pop: credit settles at OUT_DEPTH minus ops in the pipe.
    fork
      begin
        bit okc;
        for (int i = 0; i < 30; i++) begin
          send(4'($urandom_range(0, 8)), 16'($urandom), 16'($urandom), 4'(i), 5, okc);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (8) @(posedge clk);
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          chk("credit_steady", 64'(dut.credit), 64'(OUT_DEPTH - (ALU_LAT + 1)));
        end
      end
    join
    w = 0;
    while (exp_q.size() != 0 && w < 40) begin @(posedge clk); w++; end
    #1;
    chk("final_drain", 64'(exp_q.size()), 64'(0));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
